// File: rtl/bp_pkg.sv
// Shared definitions for the gshare branch predictor: counter encoding,
// reset value, default geometry and the saturating counter step.
package bp_pkg;

  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT  = 2'b10;
  localparam logic [1:0] BP_ST  = 2'b11;

  localparam logic [1:0] BP_RST_CNT = BP_WNT;

  localparam int BP_INDEX_BITS = 6;
  localparam int BP_HIST_BITS  = 4;

  function automatic logic [1:0] bp_sat_step(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != BP_ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != BP_SNT) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_pht.sv
// Pattern history table: array of 2-bit saturating counters with one
// write-first read port and one saturating update port.
module branch_pht
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = BP_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output logic [1:0]            rd_cnt_o,
  input  logic                  upd_en_i,
  input  logic [INDEX_BITS-1:0] upd_idx_i,
  input  logic                  upd_taken_i
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0] cnt_q [ENTRIES];
  logic [1:0] upd_cnt;

  assign upd_cnt = bp_sat_step(cnt_q[upd_idx_i], upd_taken_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= BP_RST_CNT;
    end else if (upd_en_i) begin
      cnt_q[upd_idx_i] <= upd_cnt;
    end
  end

  // A lookup of the entry being trained sees the trained value.
  assign rd_cnt_o = (upd_en_i && (upd_idx_i == rd_idx_i)) ? upd_cnt : cnt_q[rd_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// Gshare dynamic branch predictor: indexes the PHT at IF, registers the
// guess into ID, trains from the outcome ID resolves and keeps statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = BP_INDEX_BITS,
  parameter int HIST_BITS  = BP_HIST_BITS,
  parameter bit USE_GSHARE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] lookup_pc,
  output logic        predict_taken,
  input  logic        update_valid,
  input  logic        update_taken,
  output logic [31:0] branch_count,
  output logic [31:0] miss_count
);

  logic [HIST_BITS-1:0]  ghr_q, ghr_d, ghr_shift;
  logic [INDEX_BITS-1:0] id_idx_q, id_idx_d;
  logic [INDEX_BITS-1:0] pc_idx, lk_idx;
  logic                  predict_q, predict_d;
  logic [31:0]           branch_q, branch_d;
  logic [31:0]           miss_q, miss_d;
  logic                  upd_en, mispredict;
  logic [1:0]            pht_read;
  logic                  unused_pc;

  assign pc_idx    = lookup_pc[INDEX_BITS+1:2];
  assign unused_pc = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0]};
  assign lk_idx    = USE_GSHARE ? (pc_idx ^ INDEX_BITS'(ghr_q)) : pc_idx;

  // An update under stall is dropped entirely.
  assign upd_en     = update_valid & ~stall;
  assign mispredict = upd_en & (update_taken != predict_q);

  generate
    if (HIST_BITS == 1) begin : g_hist1
      assign ghr_shift = update_taken;
    end else begin : g_histn
      assign ghr_shift = {ghr_q[HIST_BITS-2:0], update_taken};
    end
  endgenerate

  branch_pht #(
    .INDEX_BITS (INDEX_BITS)
  ) u_pht (
    .clk         (clk),
    .rst         (rst),
    .rd_idx_i    (lk_idx),
    .rd_cnt_o    (pht_read),
    .upd_en_i    (upd_en),
    .upd_idx_i   (id_idx_q),
    .upd_taken_i (update_taken)
  );

  always_comb begin
    ghr_d     = ghr_q;
    id_idx_d  = id_idx_q;
    predict_d = predict_q;
    branch_d  = branch_q;
    miss_d    = miss_q;
    if (!stall) begin
      id_idx_d  = lk_idx;
      predict_d = pht_read[1];
    end
    if (upd_en) begin
      ghr_d = ghr_shift;
      if (branch_q != 32'hFFFF_FFFF) branch_d = branch_q + 32'd1;
    end
    if (mispredict && (miss_q != 32'hFFFF_FFFF)) miss_d = miss_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q     <= '0;
      id_idx_q  <= '0;
      predict_q <= 1'b0;
      branch_q  <= '0;
      miss_q    <= '0;
    end else begin
      ghr_q     <= ghr_d;
      id_idx_q  <= id_idx_d;
      predict_q <= predict_d;
      branch_q  <= branch_d;
      miss_q    <= miss_d;
    end
  end

  assign predict_taken = predict_q;
  assign branch_count  = branch_q;
  assign miss_count    = miss_q;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor that supplies `BranchTaken` to the decode stage and learns from the branch outcomes decode resolves. It sits beside IF:
- IF presents the fetch PC.
- The predictor registers a taken/not-taken guess aligned with the instruction's arrival in ID.
- ID reports the resolved outcome (`Branch & equal`) in the same cycle.
- Implementation: gshare-indexed table of 2-bit saturating counters, plus branch and mispredict statistics counters.

## Interface

Parameters:
- `INDEX_BITS`, 6 — log2 of table entries (64 counters).
- `HIST_BITS`, 4 — global history length; legal range 1..`INDEX_BITS`.
- `USE_GSHARE`, 1 — 1: index = PC bits XOR history; 0: PC bits only, and history is still maintained.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1 — pipeline clock; all state updates on the rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `stall` in 1 — pipeline stall, same signal that freezes ID.
- `lookup_pc` in 32 — PC of the instruction currently in IF.
- `predict_taken` out 1 — registered prediction for the instruction now in ID; drives `BranchTaken`.
- `update_valid` in 1 — ID holds a branch this cycle (`Branch & !stall`).
- `update_taken` in 1 — resolved outcome (`Branch & equal`).
- `branch_count` out 32 — resolved branches, saturating.
- `miss_count` out 32 — mispredicted branches, saturating.

## Operation

- **Lookup index:** `pc_idx = lookup_pc[INDEX_BITS+1:2]`.
  - If `USE_GSHARE`, `lk_idx = pc_idx ^ {0, ghr}`, where `ghr` is zero-extended to `INDEX_BITS`.
  - `ghr` used here is the registered (pre-update) value.
- **Pipeline registers:** `id_idx` and `predict_taken`.
  - When `!stall`: `id_idx <= lk_idx`, `predict_taken <= pht_read[1]`.
  - When `stall`: both hold.
- **Update:** when `update_valid`, the counter at `id_idx` moves +1 if `update_taken`, else -1.
  - Saturates at 2'b11 and 2'b00; never wraps.
- **History:** when `update_valid`, `ghr <= {ghr[HIST_BITS-2:0], update_taken}`.
  - For `HIST_BITS`=1, `ghr <= update_taken`.
- **Mispredict:** `update_valid & (update_taken != predict_taken)`.
  - It matches ID's `PredictMiss` by construction.
- **Statistics:** `branch_count` increments on each `update_valid`; `miss_count` increments on each mispredict. Both saturate at 32'hFFFF_FFFF.
- **Same-cycle update and lookup to the same index:** the read is write-first. `pht_read` is the post-update counter value, so the new prediction reflects the just-resolved outcome.
- **Update while stalled:** `update_valid` with `stall` high is illegal. If it is asserted anyway, the update is ignored; there are no table, history or statistics changes.
- **Counter encoding:** 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction = MSB.

## Timing

- **Reset values** (`rst` high, asynchronous; takes effect immediately, including mid-operation):
  - All counters 2'b01.
  - `ghr` 0, `id_idx` 0, `predict_taken` 0.
  - `branch_count` 0, `miss_count` 0.
- The first lookup after `rst` falls is sampled on the next rising edge.
- **Latency:** `lookup_pc` in cycle N → `predict_taken` valid in cycle N+1, the same cycle the instruction is in ID.
- **Update effect:** an update in cycle N changes the counter, `ghr` and statistics at the edge ending cycle N. A lookup of the same index in cycle N sees it through the bypass.
- **Flush:** a wrong-path IF instruction after a mispredict is harmless. Its prediction is overwritten when the refetched PC is looked up; no flush port.
- **Paths:** no combinational path from any input to any output.

## Structure

- **Package `bp_pkg`:**
  - Counter encoding constants `BP_SNT/BP_WNT/BP_WT/BP_ST`.
  - Reset counter value `BP_WNT`.
  - Default `INDEX_BITS`/`HIST_BITS`.
- **Sub-module `branch_pht`:**
  - Parameterised counter array.
  - Async reset to `BP_WNT`.
  - One read port with write-first bypass, one saturating update port.
- **Top:** index hashing, `ghr`, ID pipeline registers, statistics.

## Test plan

1. **Reset default:** release `rst`, `lookup_pc`=0x0040_0010 → next cycle `predict_taken`=0, both counts 0.
2. **Training and hysteresis** (`USE_GSHARE`=0):
   - Two taken updates at PC 0x0040_0010 → counter 11; re-lookup → `predict_taken`=1.
   - One not-taken update → counter 10, still predicts 1.
3. **Saturation** (`USE_GSHARE`=0):
   - 5 taken updates → counter 11.
   - Then 5 not-taken → counter 00; never wraps.
   - `miss_count` increments only on outcome/prediction disagreement.
4. **Bypass:** same-cycle update (taken, counter 01→10) and lookup of the same index → next cycle `predict_taken`=1.
5. **Stall hold:** assert `stall` 3 cycles while `lookup_pc` changes → `predict_taken` and `id_idx` unchanged. Then deassert → the new PC's prediction appears next cycle.
6. **Statistics, history and reset:**
   - 10 updates with 3 mispredicts → `branch_count`=10, `miss_count`=3; `ghr` equals the last 4 outcomes.
   - Assert `rst` mid-cycle → all outputs and counters at reset values immediately.
